mlx90640_fb_colorizer: RTL



---
 rtl/package_mlx.sv | 23 ++
 rtl/mlx90640_palette_rom.sv | 35 +++
 rtl/mlx90640_fb_colorizer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/package_mlx.sv
// Shared MLX90640 display types and constants.
// Imported by the colorizer top and its palette ROM.
package package_mlx;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } t_rgb565;

    localparam int MLX_COLS   = 32;
    localparam int MLX_ROWS   = 24;
    localparam int MLX_PIXELS = 768;

    localparam logic [15:0] C_SCALE_NUM = 16'hFF00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_COMMIT
    } t_scale_state;

endpackage

// File: rtl/mlx90640_palette_rom.sv
// 256-entry ironbow-style palette, black -> violet -> orange -> white.
// Synchronous read with one cycle of latency.
module mlx90640_palette_rom
    import package_mlx::*;
(
    input  logic       i_clk,
    input  logic [7:0] i_addr,
    output t_rgb565    o_rgb
);

    function automatic t_rgb565 ironbow(input logic [7:0] idx);
        t_rgb565 c;
        c.r = idx[7] ? 5'd31 : 5'(idx >> 2);
        if (idx < 8'd64)
            c.g = 6'd0;
        else if (idx < 8'd192)
            c.g = 6'((idx - 8'd64) >> 1);
        else
            c.g = 6'd63;
        if (idx < 8'd64)
            c.b = 5'(idx >> 1);
        else if (idx < 8'd128)
            c.b = 5'((8'd127 - idx) >> 1);
        else if (idx < 8'd192)
            c.b = 5'd0;
        else
            c.b = 5'((idx - 8'd192) >> 1);
        return c;
    endfunction

    always_ff @(posedge i_clk) begin
        o_rgb <= ironbow(i_addr);
    end

endmodule

// File: rtl/mlx90640_fb_colorizer.sv
// Upscales the 32x24 thermal frame into a display window and colours each pixel.
// Fixed 5-cycle pixel latency; per-frame scale computed by a serial divider.
module mlx90640_fb_colorizer
    import package_mlx::*;
#(
    parameter int unsigned p_scale_log2 = 4,
    parameter int unsigned p_x_offset   = 64,
    parameter int unsigned p_y_offset   = 48,
    parameter logic [15:0] p_bg_color   = 16'h0000,
    parameter logic        p_mirror_x   = 1'b0,
    localparam int         c_mlx_addrw  = $clog2(MLX_PIXELS + 64)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame_start,
    input  logic signed [15:0]     i_min,
    input  logic signed [15:0]     i_range,
    input  logic                   i_pix_valid,
    input  logic [9:0]             i_pix_x,
    input  logic [9:0]             i_pix_y,
    output logic                   o_fb_rd_valid,
    output logic [c_mlx_addrw-1:0] o_fb_rd_addr,
    input  logic [16:0]            i_fb_rd_data,
    output logic                   o_pix_valid,
    output logic [15:0]            o_pix_rgb,
    output logic                   o_scale_busy
);

    localparam int c_win_w = MLX_COLS << p_scale_log2;
    localparam int c_win_h = MLX_ROWS << p_scale_log2;

    // Pixel stream is valid-only: one pixel accepted every cycle valid is high, no ready.
    logic [10:0] dx, dy;
    logic        in_win;
    logic [4:0]  col_raw, col, row;
    logic        fb_bit16_unused;

    assign dx      = {1'b0, i_pix_x} - 11'(p_x_offset);
    assign dy      = {1'b0, i_pix_y} - 11'(p_y_offset);
    assign in_win  = !dx[10] && ({22'd0, dx[9:0]} < 32'(c_win_w)) &&
                     !dy[10] && ({22'd0, dy[9:0]} < 32'(c_win_h));
    assign col_raw = 5'(dx[9:0] >> p_scale_log2);
    assign row     = 5'(dy[9:0] >> p_scale_log2);
    assign col     = p_mirror_x ? (5'(MLX_COLS - 1) - col_raw) : col_raw;
    assign fb_bit16_unused = i_fb_rd_data[16];

    t_scale_state       state;
    logic signed [15:0] shadow_min, active_min;
    logic [15:0]        shadow_range, active_range_eff, active_scale;
    logic [15:0]        div_q, div_rem;
    logic [3:0]         div_cnt;
    logic [16:0]        rem_shift;
    logic               rem_ge;

    assign rem_shift = {div_rem, div_q[15]};
    assign rem_ge    = rem_shift >= {1'b0, shadow_range};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            o_scale_busy     <= 1'b0;
            shadow_min       <= '0;
            shadow_range     <= 16'd1;
            div_q            <= '0;
            div_rem          <= '0;
            div_cnt          <= '0;
            active_min       <= '0;
            active_range_eff <= 16'd1;
            active_scale     <= C_SCALE_NUM;
        end else begin
            // The whole active set changes in one edge so no pixel mixes old and new.
            if (state == ST_COMMIT) begin
                active_min       <= shadow_min;
                active_range_eff <= shadow_range;
                active_scale     <= (div_q == 16'd0) ? 16'd1 : div_q;
            end
            if (i_frame_start) begin
                shadow_min   <= i_min;
                shadow_range <= (i_range <= 16'sd0) ? 16'd1 : i_range;
                div_q        <= C_SCALE_NUM;
                div_rem      <= '0;
                div_cnt      <= '0;
                state        <= ST_DIVIDE;
                o_scale_busy <= 1'b1;
            end else begin
                case (state)
                    ST_DIVIDE: begin
                        div_rem <= rem_ge ? 16'(rem_shift - {1'b0, shadow_range})
                                          : rem_shift[15:0];
                        div_q   <= {div_q[14:0], rem_ge};
                        if (div_cnt == 4'd15) begin
                            state        <= ST_COMMIT;
                            o_scale_busy <= 1'b0;
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end
                    ST_COMMIT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [4:0]         v_pipe, w_pipe;
    logic signed [16:0] diff;
    logic [15:0]        d_clamped, d3, scale3;
    logic [31:0]        prod;
    logic [7:0]         idx_next, idx4;
    t_rgb565            rom_rgb;

    assign diff      = $signed({i_fb_rd_data[15], i_fb_rd_data[15:0]}) -
                       $signed({active_min[15], active_min});
    assign d_clamped = diff[16] ? 16'd0 :
                       (diff[15:0] > active_range_eff) ? active_range_eff : diff[15:0];
    assign prod      = {16'd0, d3} * {16'd0, scale3};
    assign idx_next  = (|prod[31:16]) ? 8'hFF : prod[15:8];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_pipe        <= '0;
            w_pipe        <= '0;
            o_fb_rd_valid <= 1'b0;
            o_fb_rd_addr  <= '0;
            d3            <= '0;
            scale3        <= '0;
            idx4          <= '0;
        end else begin
            v_pipe        <= {v_pipe[3:0], i_pix_valid};
            w_pipe        <= {w_pipe[3:0], i_pix_valid & in_win};
            o_fb_rd_valid <= i_pix_valid & in_win;
            // row*32+col is a plain concatenation because the frame is 32 wide.
            if (i_pix_valid && in_win)
                o_fb_rd_addr <= c_mlx_addrw'({row, col});
            d3     <= d_clamped;
            scale3 <= active_scale;
            idx4   <= idx_next;
        end
    end

    mlx90640_palette_rom u_palette (
        .i_clk  (i_clk),
        .i_addr (idx4),
        .o_rgb  (rom_rgb)
    );

    assign o_pix_valid = v_pipe[4];
    assign o_pix_rgb   = w_pipe[4] ? rom_rgb : (v_pipe[4] ? p_bg_color : 16'h0000);

endmodule
